// File: rtl/hack_uart_loader.sv
// UART program loader for the Hack ROM: parses a framed image, writes it word by
// word while holding the CPU in reset, then answers 'K' (loaded) or 'E' (rejected).
module hack_uart_loader #(
  parameter int          ADDR_WIDTH     = 15,
  parameter int          TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  error
);

  localparam int                GAP_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_WIDTH;
  localparam logic [7:0]        ACK_BYTE  = 8'h4B;
  localparam logic [7:0]        NAK_BYTE  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RESP
  } state_t;

  state_t                state;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [7:0]            hi_byte;
  logic [7:0]            xor_acc;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [GAP_W-1:0]      gap_cnt;

  logic                  counting;
  logic [GAP_W-1:0]      gap_inc;
  logic                  timeout;
  logic [16:0]           len_next;
  logic [16:0]           words_done;
  logic                  go_resp;
  logic                  resp_fail;

  assign busy       = (state != S_IDLE);
  assign counting   = (state != S_IDLE) && (state != S_RESP);
  assign gap_inc    = gap_cnt + GAP_W'(1);
  // The timeout takes priority over a byte landing in the same cycle.
  assign timeout    = counting && (gap_inc == GAP_LAST);
  assign len_next   = {1'b0, len_hi, rx_data};
  assign words_done = 17'(word_idx) + 17'd1;

  always_comb begin
    go_resp   = 1'b0;
    resp_fail = 1'b0;
    if (timeout) begin
      go_resp   = 1'b1;
      resp_fail = 1'b1;
    end else if (rx_valid) begin
      case (state)
        S_LEN_LO: begin
          if (len_next > MAX_WORDS) begin
            go_resp   = 1'b1;
            resp_fail = 1'b1;
          end
        end
        S_CSUM: begin
          go_resp   = 1'b1;
          resp_fail = (xor_acc != rx_data);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      len       <= '0;
      hi_byte   <= '0;
      xor_acc   <= '0;
      word_idx  <= '0;
      gap_cnt   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_rst   <= 1'b0;
      error     <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            cpu_rst  <= 1'b1;
            error    <= 1'b0;
            xor_acc  <= '0;
            word_idx <= '0;
            gap_cnt  <= '0;
            state    <= S_LEN_HI;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
            // A failed load keeps the CPU parked so a partial image never runs.
            if (!error) cpu_rst <= 1'b0;
          end
        end
        default: begin
          if (!timeout && rx_valid) begin
            gap_cnt <= '0;
            xor_acc <= xor_acc ^ rx_data;
            case (state)
              S_LEN_HI: begin
                len_hi <= rx_data;
                state  <= S_LEN_LO;
              end
              S_LEN_LO: begin
                len <= len_next[15:0];
                if (len_next == 17'd0) state <= S_CSUM;
                else                   state <= S_DATA_HI;
              end
              S_DATA_HI: begin
                hi_byte <= rx_data;
                state   <= S_DATA_LO;
              end
              S_DATA_LO: begin
                rom_we    <= 1'b1;
                rom_addr  <= word_idx[ADDR_WIDTH-1:0];
                rom_wdata <= {hi_byte, rx_data};
                word_idx  <= word_idx + 1'b1;
                if (words_done == {1'b0, len}) state <= S_CSUM;
                else                           state <= S_DATA_HI;
              end
              default: ;
            endcase
          end else begin
            gap_cnt <= gap_inc;
          end
        end
      endcase

      if (go_resp) begin
        state    <= S_RESP;
        tx_valid <= 1'b1;
        tx_data  <= resp_fail ? NAK_BYTE : ACK_BYTE;
        error    <= resp_fail;
      end
    end
  end

endmodule
